data_register_reader: RTL and testbench
=======================================

# data_register_reader

Read-side sequencer for the 16-bit data registers and data memory that feed the matrix-multiply cores. On a `start` command it fetches `length` consecutive words from `base_addr` over a fixed-latency read port and delivers them to a core over a valid/ready stream. A 2-entry output buffer with credit-based issue absorbs core backpressure without dropping words. It is the reader that consumes what the data-register write path stores.

## Interface
Parameters:
- DATA_W, 16, word width
- ADDR_W, 8, address and length width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on accepted start
- length  in  ADDR_W  word count, latched on accepted start; 0 means an empty transfer
- busy  out  1  high from the accepted start until the done pulse
- done  out  1  one-cycle pulse when a transfer completes
- mem_read  out  1  read strobe to the data store
- mem_addr  out  ADDR_W  read address, valid while mem_read is high
- mem_data  in  DATA_W  read data, valid exactly one cycle after mem_read
- out_data  out  DATA_W  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from the core

## Operation
- FSM states:
  - **IDLE**
    - start with length≠0: latch the address and remaining count, then go to FETCH.
    - start with length=0: pulse done on the next cycle and stay in IDLE; busy stays 0.
  - **FETCH**
    - Issue one read per cycle when credit is available. mem_addr increments after each issue.
    - When the last read is issued, go to DRAIN.
  - **DRAIN**
    - Wait until no read is in flight and the buffer is empty. Then pulse done and go to IDLE.
- start while busy is ignored and has no effect on the transfer in progress.
- Credit rule: issue when in_flight + fifo_count − (out_valid & out_ready) < 2.
  - in_flight is the registered mem_read from the previous cycle.
  - mem_read is therefore combinational from out_ready.
- Buffer: 2-entry FIFO, first-word-first-out.
  - mem_data is written to the FIFO the cycle after mem_read.
  - out_data is the FIFO head; out_valid = fifo_count≠0.
- Handshake:
  - A word transfers on each cycle where out_valid & out_ready is high.
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- Address arithmetic is modulo 2^ADDR_W: 8'hFF + 1 wraps to 8'h00.
- Length 255 is the maximum transfer.
- Simultaneous FIFO push and pop in the same cycle is legal; the count is unchanged.
- Overflow is impossible by the credit rule. The bench asserts it never occurs.

## Timing
- Reset values: busy=0, done=0, mem_read=0, mem_addr=0, out_valid=0, out_data=0. The FSM is in IDLE with an empty FIFO.
- Reset asserted mid-transfer:
  - Everything returns to reset values immediately (asynchronous).
  - The FIFO is flushed and an in-flight mem_data return is discarded.
  - No done pulse is generated.
- Latency: start sampled at edge t.
  - busy=1 and the first mem_read (at base_addr) are high after edge t.
  - The first word is written to the FIFO at edge t+2; out_valid is high after edge t+2.
- Throughput: one word per cycle with out_ready held high.
- done: with length N and out_ready held high, done is high after edge t+N+2 for exactly one cycle. busy falls in the same cycle that done rises.
- Earliest accepted next start is the cycle after done.

## Structure
- Shared package `core_pkg` holds:
  - DATA_W and ADDR_W defaults
  - the FSM state encoding (IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2)
  - FIFO depth constant RD_DEPTH=2
- Sub-module: `rd_fifo2`, a 2-entry synchronous FIFO with async active-low reset and a count output. It is instantiated once.
- The top level contains the FSM, the address/remaining counters, the in-flight flag, and the credit logic.

## Test plan
- **Basic read:** memory [8'h10]=16'h2445, [8'h11]=16'hE5C5; start base 8'h10 length 2; out_ready=1.
  - Stream is 16'h2445 then 16'hE5C5 on consecutive cycles, first valid two cycles after start.
  - done pulses once; busy=0 afterward.
- **Backpressure:** length 4 at 8'h20 (data 1,2,3,4); out_ready low for 5 cycles after the first valid.
  - Exactly 2 mem_reads issued, then a stall.
  - out_data holds 1.
  - On release, stream 1,2,3,4 in order with no loss or duplication.
- **Wrap and empty:**
  - Base 8'hFE length 3: reads 8'hFE, 8'hFF, 8'h00.
  - length 0: done pulse the next cycle, no mem_read, busy stays 0.
- **Start while busy:** a second start during a length-3 transfer is ignored. Exactly 3 words and one done.
- **Reset mid-transfer:** rst low during the 2nd word of a length-4 transfer.
  - All outputs are 0 immediately and no done pulse.
  - A new start after release reads correctly from its own base_addr.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants and FSM encoding for the data-register read path.
package core_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int RD_DEPTH   = 2;
    localparam int FIFO_CNT_W = $clog2(RD_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rd_fifo2.sv
// Two-entry synchronous FIFO with occupancy count; head word is always visible on pop_data.
module rd_fifo2
    import core_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     pop_data,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [DATA_W-1:0] mem [RD_DEPTH];
    logic [0:0]        wr_ptr;
    logic [0:0]        rd_ptr;

    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_register_reader.sv
// Fetches a run of words from the data store and streams them to a core with credit-limited issue.
//   state | meaning
//   IDLE  | waiting for start; a zero-length start only pulses done
//   FETCH | issuing one read per cycle while credit allows
//   DRAIN | all reads issued; waiting for in-flight data and buffer to empty
module data_register_reader
    import core_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    rd_state_t             state;
    logic [ADDR_W-1:0]     remaining;
    logic                  in_flight;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  credit_ok;
    logic                  drain_empty;

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;

    // Words already committed to the buffer, less the one leaving this cycle, must stay below depth.
    assign occupancy   = {2'b00, in_flight} + 3'(fifo_count);
    assign credit_ok   = occupancy < (3'(RD_DEPTH) + {2'b00, pop});
    assign mem_read    = (state == FETCH) && credit_ok;
    assign drain_empty = !in_flight && (fifo_count == FIFO_CNT_W'(pop));

    rd_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight),
        .push_data (mem_data),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            remaining <= '0;
            in_flight <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            in_flight <= mem_read;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            mem_addr  <= base_addr;
                            remaining <= length;
                            busy      <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (mem_read) begin
                        mem_addr  <= mem_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == ADDR_W'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_register_reader.sv
// Scoreboard bench for data_register_reader: directed scenarios plus randomized transfers.
module tb_data_register_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [7:0]  length = '0;
    logic        busy, done, mem_read, out_valid;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data = '0;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;

    logic [15:0] mem_q [256];
    logic [15:0] exp_q [$];
    logic [7:0]  addr_q [$];
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int word_cnt = 0;
    int rd_cnt   = 0;
    bit rand_ready = 0;

    always #5 clk = ~clk;

    data_register_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Fixed one-cycle read latency; junk on the bus when not reading.
    always @(posedge clk) begin
        if (mem_read) mem_data <= mem_q[mem_addr];
        else          mem_data <= 16'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer / read happens on the next rising edge if seen here.
    always @(negedge clk) begin
        if (rst) begin
            if (done) done_cnt++;
            if (mem_read) begin
                rd_cnt++;
                if (addr_q.size() == 0) chk("unexpected_read", {24'h0, mem_addr}, 32'hFFFF_FFFF);
                else chk("read_addr", {24'h0, mem_addr}, {24'h0, addr_q.pop_front()});
            end
            if (out_valid && out_ready) begin
                word_cnt++;
                if (exp_q.size() == 0) chk("unexpected_word", {16'h0, out_data}, 32'hFFFF_FFFF);
                else chk("stream_word", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
            if (dut.in_flight && dut.fifo_count == 2'd2 && !(out_valid && out_ready))
                chk("fifo_overflow", 32'd1, 32'd0);
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Returns one time unit after the edge that samples start.
    task automatic start_xfer(input logic [7:0] b, input logic [7:0] len);
        logic [7:0] a;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = len;
        a = b;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(mem_q[a]);
            addr_q.push_back(a);
            a = a + 8'd1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 8'($urandom); length = 8'($urandom);
    endtask

    task automatic wait_done(input int prev);
        int cyc = 0;
        while (done_cnt == prev && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("done_timeout", 32'(done_cnt > prev), 32'd1);
        chk("busy_after_done", {31'h0, busy}, 32'd0);
    endtask

    initial begin
        int d0, w0, r0;
        for (int i = 0; i < 256; i++) mem_q[i] = 16'($urandom);

        rst = 1'b1;
        #1 rst = 1'b0;
        #5;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_mem_read", {31'h0, mem_read}, 32'd0);
        chk("rst_mem_addr", {24'h0, mem_addr}, 32'd0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_out_data", {16'h0, out_data}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Basic read with exact latency and done timing
        mem_q[8'h10] = 16'h2445; mem_q[8'h11] = 16'hE5C5;
        out_ready = 1'b1;
        d0 = done_cnt;
        start_xfer(8'h10, 8'd2);
        @(negedge clk);
        chk("basic_busy_t", {31'h0, busy}, 32'd1);
        chk("basic_read_t", {31'h0, mem_read}, 32'd1);
        chk("basic_addr_t", {24'h0, mem_addr}, 32'h10);
        @(negedge clk);
        chk("basic_valid_t1", {31'h0, out_valid}, 32'd0);
        @(negedge clk);
        chk("basic_valid_t2", {31'h0, out_valid}, 32'd1);
        chk("basic_word0", {16'h0, out_data}, 32'h2445);
        @(negedge clk);
        chk("basic_word1", {16'h0, out_data}, 32'hE5C5);
        chk("basic_valid_t3", {31'h0, out_valid}, 32'd1);
        @(negedge clk);
        chk("basic_done_t4", {31'h0, done}, 32'd1);
        chk("basic_busy_t4", {31'h0, busy}, 32'd0);
        @(negedge clk);
        chk("basic_done_pulse", {31'h0, done}, 32'd0);
        chk("basic_done_count", 32'(done_cnt - d0), 32'd1);

        // Backpressure: only two reads outstanding, head held
        for (int i = 0; i < 4; i++) mem_q[8'h20 + i] = 16'(i + 1);
        out_ready = 1'b0;
        d0 = done_cnt; w0 = word_cnt; r0 = rd_cnt;
        start_xfer(8'h20, 8'd4);
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        chk("bp_first_valid", {31'h0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", {16'h0, out_data}, 32'd1);
            chk("bp_hold_valid", {31'h0, out_valid}, 32'd1);
            @(negedge clk);
        end
        chk("bp_reads_stalled", 32'(rd_cnt - r0), 32'd2);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(d0);
        chk("bp_words", 32'(word_cnt - w0), 32'd4);

        // Address wrap
        d0 = done_cnt; w0 = word_cnt;
        start_xfer(8'hFE, 8'd3);
        wait_done(d0);
        chk("wrap_words", 32'(word_cnt - w0), 32'd3);
        chk("wrap_addr_q_empty", 32'(addr_q.size()), 32'd0);

        // Empty transfer
        d0 = done_cnt; r0 = rd_cnt;
        start_xfer(8'h55, 8'd0);
        @(negedge clk);
        chk("empty_done", {31'h0, done}, 32'd1);
        chk("empty_busy", {31'h0, busy}, 32'd0);
        chk("empty_no_read", {31'h0, mem_read}, 32'd0);
        repeat (3) @(negedge clk);
        chk("empty_done_count", 32'(done_cnt - d0), 32'd1);
        chk("empty_read_count", 32'(rd_cnt - r0), 32'd0);

        // Start while busy is ignored
        d0 = done_cnt; w0 = word_cnt;
        start_xfer(8'h80, 8'd3);
        start = 1'b1; base_addr = 8'hC0; length = 8'd7;
        @(posedge clk); @(posedge clk); #1 start = 1'b0;
        wait_done(d0);
        repeat (4) @(negedge clk);
        chk("busy_start_words", 32'(word_cnt - w0), 32'd3);
        chk("busy_start_dones", 32'(done_cnt - d0), 32'd1);

        // Reset during the second word
        d0 = done_cnt;
        start_xfer(8'h30, 8'd4);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'd0);
        chk("mid_rst_done", {31'h0, done}, 32'd0);
        chk("mid_rst_mem_read", {31'h0, mem_read}, 32'd0);
        chk("mid_rst_mem_addr", {24'h0, mem_addr}, 32'd0);
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("mid_rst_out_data", {16'h0, out_data}, 32'd0);
        exp_q.delete(); addr_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_rst_idle_valid", {31'h0, out_valid}, 32'd0);
        w0 = word_cnt;
        start_xfer(8'h40, 8'd2);
        wait_done(d0);
        chk("post_rst_words", 32'(word_cnt - w0), 32'd2);

        // Randomized transfers under random backpressure
        rand_ready = 1;
        for (int t = 0; t < 25; t++) begin
            d0 = done_cnt; w0 = word_cnt;
            start_xfer(8'($urandom), 8'($urandom_range(1, 12)));
            wait_done(d0);
            chk("rand_exp_empty", 32'(exp_q.size()), 32'd0);
            chk("rand_addr_empty", 32'(addr_q.size()), 32'd0);
        end
        rand_ready = 0;
        @(posedge clk); #1 out_ready = 1'b1;

        // Maximum length
        d0 = done_cnt; w0 = word_cnt;
        start_xfer(8'h07, 8'd255);
        wait_done(d0);
        chk("max_len_words", 32'(word_cnt - w0), 32'd255);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
